// File: rtl/intr_ctrl.sv
// Machine-mode interrupt controller: sticky timer pending, CSR file, request/ack trap FSM and mret.
// Optional external interrupt source is enabled by defining INTR_EXT_EN.
module intr_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Timer_Intrpt,
`ifdef INTR_EXT_EN
  input  logic            ext_intrpt,
`endif
  input  logic [11:0]     csr_addr,
  input  logic            csr_we,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  input  logic            mret_i,
  output logic            intr_req,
  input  logic            intr_ack,
  input  logic [XLEN-1:0] ack_pc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] mepc_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [3:0] CAUSE_TIMER = 4'd7;
  localparam logic [3:0] CAUSE_EXT   = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_TAKE
  } state_e;

  state_e           state_q, state_d;
  logic             mstatus_mie_q, mstatus_mie_d;
  logic             mstatus_mpie_q, mstatus_mpie_d;
  logic             mie_mtie_q, mie_mtie_d;
  logic             mip_mtip_q, mip_mtip_d;
  logic [XLEN-1:2]  mtvec_q, mtvec_d;
  logic [XLEN-1:2]  mepc_q, mepc_d;
  logic [XLEN-1:0]  mcause_q, mcause_d;

  logic             ext_pend;
  logic             ext_en;
  logic             ext_hit;
  logic             tmr_hit;
  logic             eligible;
  logic [3:0]       cause;
  logic             trap_take;

  logic             wr_mstatus;
  logic             wr_mie;
  logic             wr_mtvec;
  logic             wr_mepc;
  logic             wr_mcause;
  logic             wr_mip;

  logic             unused_ack_bits;
  assign unused_ack_bits = ^ack_pc[1:0];

`ifdef INTR_EXT_EN
  logic mie_meie_q, mie_meie_d;

  assign ext_pend = ext_intrpt;
  assign ext_en   = mie_meie_q;

  always_comb begin
    mie_meie_d = mie_meie_q;
    if (wr_mie) begin
      mie_meie_d = csr_wdata[11];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_meie_q <= 1'b0;
    end else begin
      mie_meie_q <= mie_meie_d;
    end
  end
`else
  assign ext_pend = 1'b0;
  assign ext_en   = 1'b0;
`endif

  assign wr_mstatus = csr_we && (csr_addr == ADDR_MSTATUS);
  assign wr_mie     = csr_we && (csr_addr == ADDR_MIE);
  assign wr_mtvec   = csr_we && (csr_addr == ADDR_MTVEC);
  assign wr_mepc    = csr_we && (csr_addr == ADDR_MEPC);
  assign wr_mcause  = csr_we && (csr_addr == ADDR_MCAUSE);
  assign wr_mip     = csr_we && (csr_addr == ADDR_MIP);

  assign ext_hit  = ext_pend & ext_en;
  assign tmr_hit  = mip_mtip_q & mie_mtie_q;
  assign eligible = (ext_hit | tmr_hit) & mstatus_mie_q;
  assign cause    = ext_hit ? CAUSE_EXT : CAUSE_TIMER;

  // The request is withdrawn the moment eligibility drops, so a late ack sees intr_req=0.
  assign intr_req       = (state_q == ST_REQ) && eligible;
  assign trap_take      = intr_req && intr_ack;
  assign redirect_valid = (state_q == ST_TAKE);
  assign redirect_pc    = {mtvec_q, 2'b00};
  assign mepc_o         = {mepc_q, 2'b00};

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_mtie_d     = mie_mtie_q;
    mip_mtip_d     = mip_mtip_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;

    if (wr_mstatus) begin
      mstatus_mie_d  = csr_wdata[3];
      mstatus_mpie_d = csr_wdata[7];
    end
    if (wr_mie) begin
      mie_mtie_d = csr_wdata[7];
    end
    if (wr_mtvec) begin
      mtvec_d = csr_wdata[XLEN-1:2];
    end
    if (wr_mepc) begin
      mepc_d = csr_wdata[XLEN-1:2];
    end
    if (wr_mcause) begin
      mcause_d = csr_wdata;
    end
    if (wr_mip) begin
      mip_mtip_d = mip_mtip_q & csr_wdata[7];
    end

    // Trap and mret updates come after the CSR writes so they take precedence.
    unique case (state_q)
      ST_IDLE: begin
        if (mret_i) begin
          mstatus_mie_d  = mstatus_mpie_q;
          mstatus_mpie_d = 1'b1;
        end else if (eligible) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (trap_take) begin
          mepc_d         = ack_pc[XLEN-1:2];
          mcause_d       = {1'b1, {(XLEN-5){1'b0}}, cause};
          mstatus_mpie_d = mstatus_mie_q;
          mstatus_mie_d  = 1'b0;
          if (cause == CAUSE_TIMER) begin
            mip_mtip_d = 1'b0;
          end
          state_d = ST_TAKE;
        end else if (!eligible) begin
          state_d = ST_IDLE;
        end
      end
      ST_TAKE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new timer pulse beats any clear in the same cycle.
    if (Timer_Intrpt) begin
      mip_mtip_d = 1'b1;
    end
  end

  always_comb begin
    csr_rdata = '0;
    unique case (csr_addr)
      ADDR_MSTATUS: begin
        csr_rdata[3] = mstatus_mie_q;
        csr_rdata[7] = mstatus_mpie_q;
      end
      ADDR_MIE: begin
        csr_rdata[7]  = mie_mtie_q;
        csr_rdata[11] = ext_en;
      end
      ADDR_MTVEC:  csr_rdata = {mtvec_q, 2'b00};
      ADDR_MEPC:   csr_rdata = {mepc_q, 2'b00};
      ADDR_MCAUSE: csr_rdata = mcause_q;
      ADDR_MIP: begin
        csr_rdata[7]  = mip_mtip_q;
        csr_rdata[11] = ext_pend;
      end
      default: csr_rdata = '0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mip_mtip_q     <= 1'b0;
      mtvec_q        <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_mtie_q     <= mie_mtie_d;
      mip_mtip_q     <= mip_mtip_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: expectations are queued as stimulus is driven and popped when sampled.
module tb_intr_ctrl;

  localparam int XLEN = 32;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;
  localparam logic [11:0] A_UNMAP   = 12'h123;

`ifdef INTR_EXT_EN
  localparam logic [31:0] MIE_RB = 32'h0000_0880;
`else
  localparam logic [31:0] MIE_RB = 32'h0000_0080;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            Timer_Intrpt;
  logic [11:0]     csr_addr;
  logic            csr_we;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            mret_i;
  logic            intr_req;
  logic            intr_ack;
  logic [XLEN-1:0] ack_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] mepc_o;
`ifdef INTR_EXT_EN
  logic            ext_intrpt;
`endif

  intr_ctrl #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .Timer_Intrpt   (Timer_Intrpt),
`ifdef INTR_EXT_EN
    .ext_intrpt     (ext_intrpt),
`endif
    .csr_addr       (csr_addr),
    .csr_we         (csr_we),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .mret_i         (mret_i),
    .intr_req       (intr_req),
    .intr_ack       (intr_ack),
    .ack_pc         (ack_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mepc_o         (mepc_o)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sample(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic sample_csr(input logic [11:0] addr);
    csr_addr = addr;
    #1;
    sample(csr_rdata);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_addr  = addr;
    csr_wdata = data;
    csr_we    = 1'b1;
    tick();
    csr_we    = 1'b0;
  endtask

  task automatic pulse_timer();
    Timer_Intrpt = 1'b1;
    tick();
    Timer_Intrpt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 time units");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    Timer_Intrpt = 1'b0;
    csr_addr     = '0;
    csr_we       = 1'b0;
    csr_wdata    = '0;
    mret_i       = 1'b0;
    intr_ack     = 1'b0;
    ack_pc       = '0;
`ifdef INTR_EXT_EN
    ext_intrpt   = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;

    // Reset state: every CSR address and every output is zero.
    expect_push("rst_mstatus", 32'h0);
    expect_push("rst_mie",     32'h0);
    expect_push("rst_mtvec",   32'h0);
    expect_push("rst_mepc",    32'h0);
    expect_push("rst_mcause",  32'h0);
    expect_push("rst_mip",     32'h0);
    expect_push("rst_unmap",   32'h0);
    expect_push("rst_req",     32'h0);
    expect_push("rst_redir",   32'h0);
    expect_push("rst_redir_pc", 32'h0);
    expect_push("rst_mepc_o",  32'h0);
    sample_csr(A_MSTATUS);
    sample_csr(A_MIE);
    sample_csr(A_MTVEC);
    sample_csr(A_MEPC);
    sample_csr(A_MCAUSE);
    sample_csr(A_MIP);
    sample_csr(A_UNMAP);
    sample(32'(intr_req));
    sample(32'(redirect_valid));
    sample(redirect_pc);
    sample(mepc_o);

    // Basic timer trap: low mtvec bits are masked, MEIE only sticks with the external source.
    csr_write(A_MTVEC, 32'h0000_0103);
    csr_write(A_MIE, 32'h0000_0880);
    csr_write(A_MSTATUS, 32'h0000_0008);
    expect_push("cfg_mtvec", 32'h0000_0100);
    expect_push("cfg_mie",   MIE_RB);
    sample_csr(A_MTVEC);
    sample_csr(A_MIE);

    expect_push("tmr_mtip_set", 32'h0000_0080);
    expect_push("tmr_req_n1",   32'h0);
    expect_push("tmr_req_n2",   32'h1);
    pulse_timer();
    sample_csr(A_MIP);
    sample(32'(intr_req));
    tick();
    sample(32'(intr_req));

    expect_push("ack_mepc_pre", 32'h0);
    expect_push("ack_redir",    32'h1);
    expect_push("ack_redir_pc", 32'h0000_0100);
    expect_push("ack_req_low",  32'h0);
    expect_push("ack_mepc",     32'h0000_002C);
    expect_push("ack_mcause",   32'h8000_0007);
    expect_push("ack_mstatus",  32'h0000_0080);
    expect_push("ack_mip",      32'h0);
    expect_push("ack_redir_1cy", 32'h0);
    intr_ack = 1'b1;
    ack_pc   = 32'h0000_002C;
    sample_csr(A_MEPC);
    tick();
    intr_ack = 1'b0;
    sample(32'(redirect_valid));
    sample(redirect_pc);
    sample(32'(intr_req));
    sample_csr(A_MEPC);
    sample_csr(A_MCAUSE);
    sample_csr(A_MSTATUS);
    sample_csr(A_MIP);
    tick();
    sample(32'(redirect_valid));

    // mret in IDLE restores MIE from MPIE and sets MPIE.
    expect_push("mret_mstatus", 32'h0000_0088);
    expect_push("mret_mepc_o",  32'h0000_002C);
    expect_push("mret_no_req",  32'h0);
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    sample_csr(A_MSTATUS);
    sample(mepc_o);
    tick();
    sample(32'(intr_req));

    // Globally disabled: MTIP stays pending with no request until MIE is set.
    csr_write(A_MSTATUS, 32'h0);
    expect_push("dis_mip",       32'h0000_0080);
    expect_push("dis_no_req",    32'h0);
    expect_push("en_req_wr_cyc", 32'h0);
    expect_push("en_req",        32'h1);
    pulse_timer();
    tick();
    sample_csr(A_MIP);
    sample(32'(intr_req));
    csr_write(A_MSTATUS, 32'h0000_0008);
    sample(32'(intr_req));
    tick();
    sample(32'(intr_req));

    // Withdraw: clearing MIE while in REQ drops the request; a late ack is ignored.
    expect_push("wd_req_drop",  32'h0);
    expect_push("wd_no_redir",  32'h0);
    expect_push("wd_mepc",      32'h0000_002C);
    expect_push("wd_mip_kept",  32'h0000_0080);
    csr_write(A_MSTATUS, 32'h0);
    sample(32'(intr_req));
    intr_ack = 1'b1;
    ack_pc   = 32'h0000_0088;
    tick();
    intr_ack = 1'b0;
    sample(32'(redirect_valid));
    sample_csr(A_MEPC);
    sample_csr(A_MIP);

    // Software clear of MTIP, then clear coincident with a new pulse (set wins).
    expect_push("sw_clr_mip",  32'h0);
    expect_push("sw_set_wins", 32'h0000_0080);
    csr_write(A_MIP, 32'h0);
    sample_csr(A_MIP);
    Timer_Intrpt = 1'b1;
    csr_write(A_MIP, 32'h0);
    Timer_Intrpt = 1'b0;
    sample_csr(A_MIP);

    // Ack coincident with an mstatus write and a new timer pulse: trap wins, MTIP stays set.
    expect_push("co_req",       32'h1);
    expect_push("co_redir",     32'h1);
    expect_push("co_mstatus",   32'h0000_0080);
    expect_push("co_mip",       32'h0000_0080);
    expect_push("co_mepc",      32'h0000_0040);
    expect_push("co_mcause",    32'h8000_0007);
    expect_push("take_no_mret", 32'h0000_0080);
    csr_write(A_MSTATUS, 32'h0000_0008);
    tick();
    sample(32'(intr_req));
    intr_ack     = 1'b1;
    ack_pc       = 32'h0000_0040;
    Timer_Intrpt = 1'b1;
    csr_addr     = A_MSTATUS;
    csr_wdata    = 32'h0;
    csr_we       = 1'b1;
    tick();
    intr_ack     = 1'b0;
    Timer_Intrpt = 1'b0;
    csr_we       = 1'b0;
    sample(32'(redirect_valid));
    sample_csr(A_MSTATUS);
    sample_csr(A_MIP);
    sample_csr(A_MEPC);
    sample_csr(A_MCAUSE);
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    sample_csr(A_MSTATUS);

    // Reset while a request is outstanding.
    expect_push("rr_req",      32'h1);
    expect_push("rr_req_low",  32'h0);
    expect_push("rr_redir",    32'h0);
    expect_push("rr_mstatus",  32'h0);
    expect_push("rr_mie",      32'h0);
    expect_push("rr_mip",      32'h0);
    expect_push("rr_mtvec",    32'h0);
    expect_push("rr_mepc_o",   32'h0);
    expect_push("rr_idle",     32'h0);
    csr_write(A_MSTATUS, 32'h0000_0008);
    tick();
    sample(32'(intr_req));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample(32'(intr_req));
    sample(32'(redirect_valid));
    sample_csr(A_MSTATUS);
    sample_csr(A_MIE);
    sample_csr(A_MIP);
    sample_csr(A_MTVEC);
    sample(mepc_o);
    tick();
    sample(32'(intr_req));

`ifdef INTR_EXT_EN
    // External and timer both pending: cause 11 wins and MTIP survives the trap.
    expect_push("ext_mip",     32'h0000_0880);
    expect_push("ext_req",     32'h1);
    expect_push("ext_redir",   32'h1);
    expect_push("ext_mcause",  32'h8000_000B);
    expect_push("ext_mip_kept", 32'h0000_0880);
    expect_push("ext_mepc",    32'h0000_0060);
    csr_write(A_MIE, 32'h0000_0880);
    csr_write(A_MSTATUS, 32'h0000_0008);
    ext_intrpt = 1'b1;
    pulse_timer();
    sample_csr(A_MIP);
    sample(32'(intr_req));
    intr_ack = 1'b1;
    ack_pc   = 32'h0000_0060;
    tick();
    intr_ack = 1'b0;
    sample(32'(redirect_valid));
    sample_csr(A_MCAUSE);
    sample_csr(A_MIP);
    sample_csr(A_MEPC);
    ext_intrpt = 1'b0;
    tick();
`endif

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Machine-mode interrupt controller that sits directly downstream of the timer interrupt generator. It latches the one-cycle `Timer_Intrpt` pulse into a sticky pending bit and gates it with the `mie` and `mstatus` CSRs. It then runs a request/acknowledge handshake with the pipeline and updates `mepc`, `mcause` and `mstatus` when the trap is taken. It owns `mstatus`, `mie`, `mtvec`, `mepc`, `mcause` and `mip`, handles `mret`, and drives the trap-redirect PC into fetch.

## Interface
- `XLEN`, 32, data/address width of CSRs and PCs.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Timer_Intrpt`  in  1  one-cycle timer pulse from the timer interrupt generator.
- `ext_intrpt`  in  1  level external interrupt; present only with `INTR_EXT_EN`.
- `csr_addr`  in  12  CSR address from the execute stage.
- `csr_we`  in  1  CSR write strobe.
- `csr_wdata`  in  XLEN  CSR write data (already op-resolved: RW/RS/RC).
- `csr_rdata`  out  XLEN  combinational read data for `csr_addr`; 0 for unmapped addresses.
- `mret_i`  in  1  `mret` retiring this cycle.
- `intr_req`  out  1  interrupt request to pipeline.
- `intr_ack`  in  1  pipeline accepts request; `ack_pc` valid.
- `ack_pc`  in  XLEN  PC of first un-retired instruction, saved to `mepc`.
- `redirect_valid`  out  1  one-cycle fetch redirect.
- `redirect_pc`  out  XLEN  trap target, `{mtvec[XLEN-1:2],2'b00}`.
- `mepc_o`  out  XLEN  current `mepc`, used by fetch on `mret`.

## Operation
- CSR map:
  - `mstatus` 0x300: only MIE[3] and MPIE[7] are implemented; other bits read 0.
  - `mie` 0x304: MTIE[7] and MEIE[11].
  - `mtvec` 0x305: direct mode only; bits [1:0] read 0.
  - `mepc` 0x341: bits [1:0] read 0.
  - `mcause` 0x342: full XLEN.
  - `mip` 0x344: MTIP[7] is sticky and cleared by a CSR write of 0. MEIP[11] is read-only and mirrors `ext_intrpt`.
- Pending:
  - MTIP is set on the edge after `Timer_Intrpt`=1.
  - MTIP is cleared when the timer trap is taken or when software writes 0 to it.
- Eligible = `(mip & mie) != 0 && mstatus.MIE`. Priority: external (cause 11) over timer (cause 7).
- FSM states:
  - IDLE → REQ: next edge when Eligible && !`mret_i`.
  - REQ: `intr_req`=1. On `intr_ack`:
    - `mepc` ← `ack_pc`
    - `mcause` ← `{1'b1, cause}`
    - MPIE ← MIE, MIE ← 0
    - clear MTIP if cause is 7
    - go to TAKE
  - REQ withdraw: if Eligible drops (software clears MIE, mie or mip) with no ack, return to IDLE and deassert `intr_req`.
  - TAKE: `redirect_valid`=1 for exactly one cycle, then IDLE.
- `mret_i` in IDLE: MIE ← MPIE, MPIE ← 1. `mret_i` outside IDLE is ignored.
- `intr_ack` while `intr_req`=0 is ignored.

## Timing
- Reset values:
  - all implemented CSR bits = 0; state IDLE.
  - `intr_req`, `redirect_valid` = 0; `redirect_pc`, `mepc_o` = 0; `csr_rdata` = 0 for any address.
- CSR writes take effect on the next edge. `csr_rdata` reflects pre-write state in the write cycle.
- Latency, timer pulse to request:
  - pulse at edge N → MTIP=1 at N+1 → `intr_req`=1 at N+2, if enabled.
- Latency, ack to redirect: ack at edge M → `redirect_valid`=1 in cycle M+1 → 0 at M+2.
- Ack and CSR write in the same cycle: trap updates win for `mstatus`, `mepc`, `mcause`. Writes to other CSRs apply normally.
- New `Timer_Intrpt` in the same cycle a timer trap clears MTIP: set wins, so MTIP stays 1.
- Software MTIP-clear write coincident with `Timer_Intrpt`: set wins.
- `rst` asserted in any state: next edge returns all state to reset values, including a pending REQ or TAKE.

## Configuration
- `INTR_EXT_EN` defined:
  - `ext_intrpt` port, MEIP and MEIE exist.
  - cause 11 is taken with priority over the timer.
- `INTR_EXT_EN` undefined:
  - port absent; MEIP and MEIE read 0 and ignore writes.
  - only cause 7 is possible.

## Test plan
- After reset, read every CSR address → all 0. `intr_req`=0, `redirect_valid`=0.
- `mtvec`=0x100, `mie`=0x80, `mstatus`=0x8, pulse `Timer_Intrpt` → `intr_req` two edges later. Ack with `ack_pc`=0x2C, then check:
  - `mepc`=0x2C, `mcause`=0x80000007
  - `mstatus`=0x80, MTIP=0
  - one-cycle redirect to 0x100
- Same as the previous scenario, but `mstatus`=0 → MTIP reads 1 and no `intr_req`. Then write `mstatus`=0x8 → `intr_req` asserts next edge.
- While in REQ, write `mstatus`=0 before ack → `intr_req` drops next edge. A later ack is ignored; `mepc` is unchanged.
- After a taken trap (`mstatus`=0x80), assert `mret_i` → `mstatus`=0x88, and `mepc_o` equals the saved PC.
- With `INTR_EXT_EN`: `ext_intrpt`=1 and MTIP=1, both enabled → `mcause`=0x8000000B and MTIP remains 1.
